// File: rtl/header_fetch_if.sv
// AXI4 read-address/read-data channels plus the 32-bit word stream toward the hash core.
// The fetch engine is the master; the interconnect and hash core together form the slave side.
interface header_fetch_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int ID_WIDTH      = 6,
    parameter int BUS_LEN_WIDTH = 4
) ();
    logic                     arvalid;
    logic                     arready;
    logic [ADDR_WIDTH-1:0]    araddr;
    logic [BUS_LEN_WIDTH-1:0] arlen;
    logic [ID_WIDTH-1:0]      arid;
    logic [2:0]               arsize;
    logic [1:0]               arburst;

    logic                     rvalid;
    logic                     rready;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     rlast;
    logic [1:0]               rresp;
    logic [ID_WIDTH-1:0]      rid;

    logic                     Out_valid;
    logic                     Out_ready;
    logic [31:0]              Out_data;
    logic                     Out_last;

    modport master (
        output arvalid, araddr, arlen, arid, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rlast, rresp, rid,
        output rready,
        output Out_valid, Out_data, Out_last,
        input  Out_ready
    );

    modport slave (
        input  arvalid, araddr, arlen, arid, arsize, arburst,
        output arready,
        output rvalid, rdata, rlast, rresp, rid,
        input  rready,
        input  Out_valid, Out_data, Out_last,
        output Out_ready
    );
endinterface

// File: rtl/header_fetch.sv
// Fetches Num_beats 64-bit beats over AXI4 read bursts (16-beat max, never crossing 4 KB)
// and streams them out as 32-bit words, low half first, through a one-beat holding register.
module header_fetch #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int ID_WIDTH      = 6,
    parameter int BUS_LEN_WIDTH = 4,
    parameter int FETCH_ID      = 0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_addr,
    input  logic [7:0]            Num_beats,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    header_fetch_if.master        bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_e;

    localparam int MAX_BEATS = 1 << BUS_LEN_WIDTH;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [7:0]               remain_q, remain_d;
    logic [BUS_LEN_WIDTH-1:0] arlen_q, arlen_d;
    logic                     arvalid_q, arvalid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     hold_valid_q, hold_valid_d;
    logic                     half_q, half_d;
    logic                     hold_last_q, hold_last_d;
    logic [DATA_WIDTH-1:0]    hold_data_q, hold_data_d;

    logic                     rready_c;
    logic                     r_fire;
    logic                     out_fire;
    logic [BUS_LEN_WIDTH:0]   burst_beats;
    logic [ADDR_WIDTH-1:0]    next_addr;
    logic [7:0]               next_remain;

    // Burst length limited by remaining beats, the ARLEN range and the beats left in this 4 KB page.
    function automatic logic [BUS_LEN_WIDTH-1:0] calc_arlen(input logic [8:0] page_beat,
                                                            input logic [7:0] rem);
        logic [9:0] to_page_end;
        logic [9:0] n;
        to_page_end = 10'd512 - {1'b0, page_beat};
        n = {2'b00, rem};
        if (to_page_end < n) n = to_page_end;
        if (n > 10'(MAX_BEATS)) n = 10'(MAX_BEATS);
        n = n - 10'd1;
        return n[BUS_LEN_WIDTH-1:0];
    endfunction

    assign out_fire    = hold_valid_q && bus.Out_ready;
    assign rready_c    = (state_q == DATA) && (!hold_valid_q || (out_fire && half_q));
    assign r_fire      = bus.rvalid && rready_c;
    assign burst_beats = {1'b0, arlen_q} + {{BUS_LEN_WIDTH{1'b0}}, 1'b1};
    assign next_addr   = addr_q + ADDR_WIDTH'({burst_beats, 3'b000});
    assign next_remain = remain_q - 8'(burst_beats);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        hold_valid_d = hold_valid_q;
        half_d       = half_q;
        hold_last_d  = hold_last_q;
        hold_data_d  = hold_data_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    error_d = 1'b0;
                    if (Num_beats == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d    = Base_addr;
                        remain_d  = Num_beats;
                        arlen_d   = calc_arlen(Base_addr[11:3], Num_beats);
                        arvalid_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = ADDR;
                    end
                end
            end
            ADDR: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (r_fire && bus.rlast) begin
                    addr_d   = next_addr;
                    remain_d = next_remain;
                    if (next_remain != 8'd0) begin
                        arlen_d   = calc_arlen(next_addr[11:3], next_remain);
                        arvalid_d = 1'b1;
                        state_d   = ADDR;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire && half_q && hold_last_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new beat may land in the same cycle the high word leaves, keeping one word per cycle.
        if (r_fire) begin
            hold_data_d  = bus.rdata;
            hold_valid_d = 1'b1;
            half_d       = 1'b0;
            hold_last_d  = bus.rlast && (remain_q == 8'(burst_beats));
            if (bus.rresp != 2'b00 || bus.rid != ID_WIDTH'(FETCH_ID)) error_d = 1'b1;
        end else if (out_fire) begin
            if (half_q) begin
                hold_valid_d = 1'b0;
                half_d       = 1'b0;
            end else begin
                half_d = 1'b1;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            half_q       <= 1'b0;
            hold_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            hold_valid_q <= hold_valid_d;
            half_q       <= half_d;
            hold_last_q  <= hold_last_d;
        end
    end

    // NOTE: the data register is qualified by hold_valid_q, so it needs no reset.
    always_ff @(posedge Clk) begin
        hold_data_q <= hold_data_d;
    end

    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Error         = error_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = addr_q;
    assign bus.arlen     = arlen_q;
    assign bus.arid      = ID_WIDTH'(FETCH_ID);
    assign bus.arsize    = 3'd3;
    assign bus.arburst   = 2'b01;
    assign bus.rready    = rready_c;
    assign bus.Out_valid = hold_valid_q;
    assign bus.Out_data  = half_q ? hold_data_q[63:32] : hold_data_q[31:0];
    assign bus.Out_last  = hold_valid_q && half_q && hold_last_q;
endmodule

// File: tb/tb_header_fetch.sv
// Self-checking bench for header_fetch: a randomised AXI read slave and word sink run cycle by
// cycle against a reference model of the expected bursts and word stream.
`timescale 1ns/1ps
module tb_header_fetch;
    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 64;
    localparam int ID_WIDTH      = 6;
    localparam int BUS_LEN_WIDTH = 4;
    localparam int FETCH_ID      = 0;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [31:0] Base_addr;
    logic [7:0]  Num_beats;
    logic        Busy;
    logic        Done;
    logic        Error;

    header_fetch_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .ID_WIDTH(ID_WIDTH), .BUS_LEN_WIDTH(BUS_LEN_WIDTH)
    ) bus ();

    header_fetch #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
        .BUS_LEN_WIDTH(BUS_LEN_WIDTH), .FETCH_ID(FETCH_ID)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Base_addr(Base_addr), .Num_beats(Num_beats),
        .Busy(Busy), .Done(Done), .Error(Error), .bus(bus)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [31:0] addr; logic [3:0] len; } ar_t;
    typedef struct { logic [31:0] data; logic last; } word_t;

    ar_t   exp_ar[$];
    word_t exp_words[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ar_pct = 100, r_pct = 100, rdy_pct = 100;
    bit stall = 0;
    int err_beat = -1, bad_id_beat = -1, beat_cnt = 0;
    bit burst_active = 0, r_fired = 0;
    logic [31:0] r_addr;
    int r_left = 0;
    int ar_count = 0, words_out = 0, done_cnt = 0, last_hs_cyc = -10;
    bit hs_check_en = 0, exp_error = 0;
    bit prev_stall = 0, prev_ar_wait = 0;
    logic [31:0] prev_data, prev_araddr;
    logic [3:0]  prev_arlen;

    // Memory image: each 64-bit beat is a fixed scramble of its own address.
    function automatic logic [63:0] mem_beat(input logic [31:0] a);
        return {a ^ 32'h5A5A_0F0F, (a * 32'd2654435761) ^ 32'h0000_1357};
    endfunction

    task automatic agent_clear();
        exp_ar.delete();
        exp_words.delete();
        burst_active = 0;
        r_left       = 0;
        r_fired      = 0;
        bus.rvalid   = 1'b0;
        bus.rlast    = 1'b0;
        prev_stall   = 0;
        prev_ar_wait = 0;
    endtask

    // One clock: drive slave/sink inputs after the falling edge, then predict the rising-edge handshakes.
    task automatic tick();
        ar_t   e;
        word_t w;
        @(negedge Clk);
        cyc++;
        bus.arready = ($urandom_range(1, 100) <= ar_pct);
        if (r_fired) begin
            bus.rvalid = 1'b0;
            r_fired    = 0;
        end
        if (!bus.rvalid && burst_active && r_left > 0 && ($urandom_range(1, 100) <= r_pct)) begin
            bus.rvalid = 1'b1;
            bus.rdata  = mem_beat(r_addr);
            bus.rlast  = (r_left == 1);
            bus.rresp  = (beat_cnt == err_beat) ? 2'd2 : 2'd0;
            bus.rid    = (beat_cnt == bad_id_beat) ? ID_WIDTH'(FETCH_ID + 1) : ID_WIDTH'(FETCH_ID);
        end
        bus.Out_ready = !stall && ($urandom_range(1, 100) <= rdy_pct);
        #1;
        if (Rst) begin
            agent_clear();
            return;
        end

        if (prev_ar_wait) begin
            checks++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== prev_araddr || bus.arlen !== prev_arlen) begin
                errors++;
                $display("FAIL ar_stable: arvalid=%0b araddr=%h arlen=%0d, required arvalid=1 araddr=%h arlen=%0d",
                         bus.arvalid, bus.araddr, bus.arlen, prev_araddr, prev_arlen);
            end
        end
        if (bus.arvalid && bus.arready) begin
            ar_count++;
            checks++;
            if (burst_active || exp_ar.size() == 0) begin
                errors++;
                $display("FAIL ar_issue: AR at %h while burst_active=%0b expected_left=%0d, required no AR",
                         bus.araddr, burst_active, exp_ar.size());
            end else begin
                e = exp_ar.pop_front();
                if (bus.araddr !== e.addr || bus.arlen !== e.len || bus.arsize !== 3'd3 ||
                    bus.arburst !== 2'd1 || bus.arid !== ID_WIDTH'(FETCH_ID)) begin
                    errors++;
                    $display("FAIL ar_fields: addr=%h len=%0d size=%0d burst=%0d id=%0d, required addr=%h len=%0d size=3 burst=1 id=%0d",
                             bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid, e.addr, e.len, FETCH_ID);
                end
                burst_active = 1;
                r_addr       = bus.araddr;
                r_left       = int'(bus.arlen) + 1;
            end
        end
        prev_ar_wait = bus.arvalid && !bus.arready;
        prev_araddr  = bus.araddr;
        prev_arlen   = bus.arlen;

        if (bus.rvalid && bus.rready) begin
            r_fired = 1;
            beat_cnt++;
            r_addr += 32'd8;
            r_left--;
            if (r_left == 0) burst_active = 0;
        end

        if (bus.Out_valid && !bus.Out_ready) begin
            checks++;
            if (bus.rready !== 1'b0) begin
                errors++;
                $display("FAIL rready_full: rready=%0b with held word stalled, required 0", bus.rready);
            end
        end
        if (prev_stall) begin
            checks++;
            if (bus.Out_valid !== 1'b1 || bus.Out_data !== prev_data) begin
                errors++;
                $display("FAIL out_stable: Out_valid=%0b Out_data=%h, required 1 and %h",
                         bus.Out_valid, bus.Out_data, prev_data);
            end
        end
        if (bus.Out_valid && bus.Out_ready) begin
            words_out++;
            checks++;
            if (exp_words.size() == 0) begin
                errors++;
                $display("FAIL out_extra: word %h last=%0b, required no word", bus.Out_data, bus.Out_last);
            end else begin
                w = exp_words.pop_front();
                if (bus.Out_data !== w.data || bus.Out_last !== w.last) begin
                    errors++;
                    $display("FAIL out_word: data=%h last=%0b, required data=%h last=%0b",
                             bus.Out_data, bus.Out_last, w.data, w.last);
                end
                if (w.last) last_hs_cyc = cyc;
            end
        end
        if (Done) begin
            done_cnt++;
            if (hs_check_en) begin
                checks++;
                if (cyc != last_hs_cyc + 1 || exp_words.size() != 0) begin
                    errors++;
                    $display("FAIL done_timing: Done at cycle %0d with %0d words pending, required cycle %0d with 0 pending",
                             cyc, exp_words.size(), last_hs_cyc + 1);
                end
            end
        end
        prev_stall = bus.Out_valid && !bus.Out_ready;
        prev_data  = bus.Out_data;
    endtask

    // Expected bursts come straight from the split rule: min(remaining, 16, beats to next 4 KB).
    task automatic start_fetch(input logic [31:0] base, input int n);
        logic [31:0] a;
        logic [63:0] d;
        int rem, b, bb;
        a = base;
        rem = n;
        while (rem > 0) begin
            b  = (rem < 16) ? rem : 16;
            bb = (4096 - int'(a % 32'd4096)) / 8;
            if (bb < b) b = bb;
            exp_ar.push_back('{addr: a, len: 4'(b - 1)});
            a   += 32'(b * 8);
            rem -= b;
        end
        for (int i = 0; i < n; i++) begin
            d = mem_beat(base + 32'(i * 8));
            exp_words.push_back('{data: d[31:0], last: 1'b0});
            exp_words.push_back('{data: d[63:32], last: (i == n - 1)});
        end
        beat_cnt    = 0;
        ar_count    = 0;
        words_out   = 0;
        hs_check_en = (n > 0);
        last_hs_cyc = -10;
        Base_addr   = base;
        Num_beats   = 8'(n);
        Start       = 1'b1;
        tick();
        Start = 1'b0;
        if (n > 0) begin
            checks++;
            if (Busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_start: Busy=%0b after Start, required 1", Busy);
            end
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) tick();
        Rst = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        int start_cnt = done_cnt;
        int k = 0;
        while (done_cnt == start_cnt && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (done_cnt == start_cnt) begin
            errors++;
            $display("FAIL %s_timeout: no Done within %0d cycles, required one Done", name, budget);
            do_reset();
            return;
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: Busy=%0b with Done, required 0", name, Busy);
        end
        checks++;
        if (exp_words.size() != 0 || exp_ar.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d words and %0d ARs missing, required 0 and 0",
                     name, exp_words.size(), exp_ar.size());
        end
        checks++;
        if (Error !== exp_error) begin
            errors++;
            $display("FAIL %s_error: Error=%0b, required %0b", name, Error, exp_error);
        end
        repeat (2) tick();
        checks++;
        if (done_cnt != start_cnt + 1) begin
            errors++;
            $display("FAIL %s_done_count: %0d Done pulses, required 1", name, done_cnt - start_cnt);
        end
    endtask

    task automatic check_counts(input string name, input int ars, input int words);
        checks++;
        if (ar_count != ars || words_out != words) begin
            errors++;
            $display("FAIL %s_counts: %0d ARs %0d words, required %0d ARs %0d words",
                     name, ar_count, words_out, ars, words);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({Busy, Done, Error, bus.arvalid, bus.rready, bus.Out_valid, bus.Out_last} !== 7'b0) begin
            errors++;
            $display("FAIL %s: Busy,Done,Error,arvalid,rready,Out_valid,Out_last=%b, required 0000000", name,
                     {Busy, Done, Error, bus.arvalid, bus.rready, bus.Out_valid, bus.Out_last});
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset_state");
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_single_burst();
        ar_pct = 100; r_pct = 100; rdy_pct = 100; exp_error = 0;
        start_fetch(32'h0000_1000, 4);
        wait_done("single_burst", 200);
        check_counts("single_burst", 1, 8);
    endtask

    task automatic test_multi_burst();
        start_fetch(32'h0000_0000, 40);
        wait_done("multi_burst", 1000);
        check_counts("multi_burst", 3, 80);
    endtask

    task automatic test_4k_cross();
        ar_pct = 60; r_pct = 70;
        start_fetch(32'h0000_0FF0, 4);
        wait_done("cross_4k", 500);
        check_counts("cross_4k", 2, 8);
    endtask

    task automatic test_stall();
        int k = 0;
        ar_pct = 100; r_pct = 100; rdy_pct = 100;
        start_fetch(32'h0000_2000, 8);
        while (words_out < 3 && k < 200) begin
            tick();
            k++;
        end
        stall = 1;
        repeat (10) tick();
        checks++;
        if (bus.rready !== 1'b0 || bus.Out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: rready=%0b Out_valid=%0b after stall, required 0 and 1",
                     bus.rready, bus.Out_valid);
        end
        stall = 0;
        wait_done("stall", 500);
        check_counts("stall", 1, 16);
    endtask

    task automatic test_rresp_error();
        err_beat = 1; exp_error = 1; rdy_pct = 70;
        start_fetch(32'h0000_3000, 4);
        wait_done("rresp_error", 500);
        check_counts("rresp_error", 1, 8);
        repeat (3) tick();
        checks++;
        if (Error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: Error=%0b while idle, required 1", Error);
        end
        err_beat = -1;
        start_fetch(32'h0000_3100, 2);
        checks++;
        if (Error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: Error=%0b after Start, required 0", Error);
        end
        exp_error = 0;
        wait_done("after_error", 500);
    endtask

    task automatic test_bad_id();
        bad_id_beat = 0; exp_error = 1;
        start_fetch(32'h0000_5008, 3);
        wait_done("bad_id", 500);
        check_counts("bad_id", 1, 6);
        bad_id_beat = -1;
    endtask

    task automatic test_zero_beats();
        int start_cnt = done_cnt;
        exp_error = 0;
        start_fetch(32'h0000_6000, 0);
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Error !== 1'b0 || bus.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: Done=%0b Busy=%0b Error=%0b arvalid=%0b, required 1 0 0 0",
                     Done, Busy, Error, bus.arvalid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (Done !== 1'b0 || bus.arvalid !== 1'b0) begin
                errors++;
                $display("FAIL zero_idle: Done=%0b arvalid=%0b at cycle %0d, required 0 0", Done, bus.arvalid, i);
            end
        end
        checks++;
        if (done_cnt != start_cnt + 1) begin
            errors++;
            $display("FAIL zero_done_count: %0d Done pulses, required 1", done_cnt - start_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        ar_pct = 100; r_pct = 100; rdy_pct = 100;
        start_fetch(32'h0000_7000, 64);
        while (beat_cnt < 3 && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (!burst_active) begin
            errors++;
            $display("FAIL reset_mid_setup: burst_active=%0b before reset, required 1", burst_active);
        end
        Rst = 1'b1;
        tick();
        check_all_zero("reset_mid");
        Rst = 1'b0;
        tick();
        start_fetch(32'h0000_7100, 5);
        wait_done("after_reset", 500);
        check_counts("after_reset", 1, 10);
    endtask

    task automatic test_random();
        logic [31:0] base;
        int n, off;
        for (int i = 0; i < 8; i++) begin
            off = ($urandom_range(0, 1) == 1) ? (4096 - 8 * int'($urandom_range(1, 20)))
                                              : 8 * int'($urandom_range(0, 511));
            base      = 32'(int'($urandom_range(0, 15)) * 4096 + off);
            n         = int'($urandom_range(1, 60));
            ar_pct    = int'($urandom_range(40, 100));
            r_pct     = int'($urandom_range(40, 100));
            rdy_pct   = int'($urandom_range(40, 100));
            err_beat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            exp_error = (err_beat >= 0);
            start_fetch(base, n);
            wait_done("random", 5000);
            check_counts("random", (exp_ar.size() == 0) ? ar_count : -1, 2 * n);
        end
        err_beat = -1;
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Base_addr = '0; Num_beats = '0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
        bus.rresp = 2'd0; bus.rid = '0; bus.Out_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_4k_cross();
        test_stall();
        test_rresp_error();
        test_bad_id();
        test_zero_beats();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
